// File: rtl/regfile_write_bank.sv
// regfile_write_bank
// Write side of the integer register file. A tree of 1:2 enable decoders
// turns the write address into one-hot row enables. Each row is an enabled
// register that holds its value through a 2:1 feedback select. The block also
// keeps a per-row dirty bitmap, a saturating count of committed writes and
// the address of the most recent committed write.
// Writes to the hardwired-zero row are discarded entirely.

module regfile_write_bank #(
    parameter int WIDTH    = 64,
    parameter int NREGS    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              dirty_clr,
    output logic [WIDTH-1:0]  regs_out [NREGS-1:0],
    output logic [NREGS-1:0]  wr_onehot,
    output logic [NREGS-1:0]  dirty,
    output logic [CNT_W-1:0]  wr_count,
    output logic [ADDR_W-1:0] last_addr
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // The tree expands one address bit per level, starting from the MSB.
    // Each live node splits into two children, and the select bit picks one
    // of them. A node at level l therefore carries the top l address bits as
    // its index, and the leaves come out in natural address order.
    // Because the root is wr_en, an X address cannot raise an enable while
    // wr_en is low.
    function automatic logic [NREGS-1:0] tree_decode(
        input logic              en,
        input logic [ADDR_W-1:0] addr
    );
        logic [NREGS-1:0] lvl;
        logic [NREGS-1:0] nxt;
        lvl    = '0;
        lvl[0] = en;
        for (int l = 0; l < ADDR_W; l++) begin
            nxt = '0;
            for (int j = 0; j < NREGS / 2; j++) begin
                nxt[2*j]   = lvl[j] & ~addr[ADDR_W-1-l];
                nxt[2*j+1] = lvl[j] &  addr[ADDR_W-1-l];
            end
            lvl = nxt;
        end
        return lvl;
    endfunction

    logic [WIDTH-1:0]  r_rows [NREGS-1:0];
    logic [NREGS-1:0]  r_dirty;
    logic [CNT_W-1:0]  r_count;
    logic [ADDR_W-1:0] r_last;
    logic [NREGS-1:0]  w_onehot;
    logic              w_commit;

    // Decode the write enables, then mask the hardwired-zero row so that a
    // write to it reaches nothing.
    always_comb begin
        w_onehot           = tree_decode(wr_en, wr_addr);
        w_onehot[ZERO_REG] = 1'b0;
        w_commit           = |w_onehot;
    end

    // Row storage. Each row has an enabled flop with a hold path, so
    // wr_addr and wr_data are never sampled into a row that is not enabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_rows[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                r_rows[i] <= w_onehot[i] ? wr_data : r_rows[i];
            end
        end
    end

    // Dirty bitmap. A clear and a commit in the same cycle leave only the
    // newly written row marked.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dirty <= '0;
        end else if (dirty_clr) begin
            r_dirty <= w_onehot;
        end else begin
            r_dirty <= r_dirty | w_onehot;
        end
    end

    // Saturating count of committed writes. dirty_clr does not reset it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (w_commit && (r_count != CNT_MAX)) begin
            r_count <= r_count + CNT_W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    // Address of the most recent committed write. Discarded writes leave it
    // unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last <= '0;
        end else if (w_commit) begin
            r_last <= wr_addr;
        end else begin
            r_last <= r_last;
        end
    end

    assign regs_out  = r_rows;
    assign wr_onehot = w_onehot;
    assign dirty     = r_dirty;
    assign wr_count  = r_count;
    assign last_addr = r_last;

endmodule
